// File: rtl/core_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_wb_pkg
// Brief    : Shared types and constants for the register-file write-back path.
// Revision : 1.0
// ============================================================================
package core_wb_pkg;

    localparam int WB_XLEN    = 64;
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MDU = 2;
    localparam int WB_N_SRC   = 3;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

endpackage : core_wb_pkg
`default_nettype wire

// File: rtl/core_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : core_wb_fifo
// Brief    : Per-source result FIFO with a per-entry rd view for the pend mask.
// Revision : 1.0
// ============================================================================
module core_wb_fifo
    import core_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enq,
    input  wb_req_t            i_enq_data,
    input  logic               i_deq,
    output logic               o_full,
    output logic               o_empty,
    output wb_req_t            o_head,
    output logic [DEPTH-1:0]   o_ent_vld,
    output logic [DEPTH*5-1:0] o_ent_rd
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    wb_req_t       r_mem [DEPTH];
    logic [AW:0]   w_count;
    logic [AW-1:0] w_off;
    logic          w_do_enq;
    logic          w_do_deq;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_enq = i_enq && !o_full;
    assign w_do_deq = i_deq && !o_empty;
    assign o_head   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_enq) r_mem[r_wr_ptr[AW-1:0]] <= i_enq_data;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        o_ent_vld = '0;
        o_ent_rd  = '0;
        w_off     = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_off          = AW'(e) - r_rd_ptr[AW-1:0];
            o_ent_vld[e]   = ({1'b0, w_off} < w_count);
            o_ent_rd[e*5 +: 5] = r_mem[e].rd;
        end
    end

endmodule : core_wb_fifo
`default_nettype wire

// File: rtl/core_rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : core_rf_wb_arb
// Brief    : Round-robin write-back arbiter driving the RF write port.
// Revision : 1.0
// ============================================================================
module core_rf_wb_arb
    import core_wb_pkg::*;
#(
    parameter int N_SRC = WB_N_SRC,
    parameter int DEPTH = 2,
    parameter int XLEN  = WB_XLEN
) (
    input  logic                  i_wb_clk,
    input  logic                  i_wb_rst_n,
    input  logic [N_SRC-1:0]      i_wb_valid,
    output logic [N_SRC-1:0]      o_wb_ready,
    input  logic [N_SRC*5-1:0]    i_wb_rd,
    input  logic [N_SRC*XLEN-1:0] i_wb_data,
    output logic                  o_wb_we3,
    output logic [4:0]            o_wb_a3,
    output logic [XLEN-1:0]       o_wb_wd3,
    output logic [31:0]           o_wb_pend,
    output logic                  o_wb_idle
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    wb_req_t            w_head    [N_SRC];
    logic [DEPTH-1:0]   w_ent_vld [N_SRC];
    logic [DEPTH*5-1:0] w_ent_rd  [N_SRC];
    logic [N_SRC-1:0]   w_empty;
    logic [N_SRC-1:0]   w_full;
    logic [N_SRC-1:0]   w_deq;

    logic [PW-1:0]      r_ptr;
    logic               r_we3;
    logic [4:0]         r_a3;
    logic [XLEN-1:0]    r_wd3;

    logic               w_grant;
    logic [PW-1:0]      w_gidx;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_idx;
    logic [31:0]        w_pend;

    generate
        for (genvar s = 0; s < N_SRC; s++) begin : g_src
            wb_req_t w_req;
            logic    w_enq;

            assign w_req.rd     = i_wb_rd[s*5 +: 5];
            assign w_req.data   = i_wb_data[s*XLEN +: XLEN];
            // rd==0 completes the handshake but is never queued.
            assign w_enq        = i_wb_valid[s] && (w_req.rd != 5'd0);
            assign o_wb_ready[s] = !w_full[s];
            assign w_deq[s]     = w_grant && (w_gidx == PW'(s));

            core_wb_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .i_clk      (i_wb_clk),
                .i_rst_n    (i_wb_rst_n),
                .i_enq      (w_enq),
                .i_enq_data (w_req),
                .i_deq      (w_deq[s]),
                .o_full     (w_full[s]),
                .o_empty    (w_empty[s]),
                .o_head     (w_head[s]),
                .o_ent_vld  (w_ent_vld[s]),
                .o_ent_rd   (w_ent_rd[s])
            );
        end
    endgenerate

    // Scan downward so the candidate nearest the pointer wins.
    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N_SRC)) w_sum = w_sum - (PW+1)'(N_SRC);
            w_idx = w_sum[PW-1:0];
            if (!w_empty[w_idx]) begin
                w_grant = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_ptr <= '0;
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_gidx == PW'(N_SRC - 1)) ? '0 : w_gidx + 1'b1;
            r_we3 <= 1'b1;
            r_a3  <= w_head[w_gidx].rd;
            r_wd3 <= w_head[w_gidx].data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int s = 0; s < N_SRC; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_ent_vld[s][e]) w_pend[w_ent_rd[s][e*5 +: 5]] = 1'b1;
            end
        end
        if (r_we3) w_pend[r_a3] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign o_wb_we3  = r_we3;
    assign o_wb_a3   = r_a3;
    assign o_wb_wd3  = r_wd3;
    assign o_wb_pend = w_pend;
    assign o_wb_idle = (&w_empty) && !r_we3;

endmodule : core_rf_wb_arb
`default_nettype wire

// File: tb/tb_core_rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_rf_wb_arb
// Brief    : Directed scoreboard bench for the write-back arbiter.
// Revision : 1.0
// ============================================================================
module tb_core_rf_wb_arb;
    import core_wb_pkg::*;

    localparam int N_SRC = 3;
    localparam int DEPTH = 2;
    localparam int XLEN  = 64;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_SRC-1:0]      valid = '0;
    logic [N_SRC-1:0]      ready;
    logic [N_SRC*5-1:0]    rd = '0;
    logic [N_SRC*XLEN-1:0] data = '0;
    logic                  we3;
    logic [4:0]            a3;
    logic [XLEN-1:0]       wd3;
    logic [31:0]           pend;
    logic                  idle;

    typedef struct packed {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } exp_t;

    exp_t            exp_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    logic [XLEN-1:0] rf_model [32];
    logic [5:0]      lsu_rdy_tbl = 6'b101011;

    core_rf_wb_arb #(.N_SRC(N_SRC), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_valid (valid),
        .o_wb_ready (ready),
        .i_wb_rd    (rd),
        .i_wb_data  (data),
        .o_wb_we3   (we3),
        .o_wb_a3    (a3),
        .o_wb_wd3   (wd3),
        .o_wb_pend  (pend),
        .o_wb_idle  (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic [4:0] r, input logic [XLEN-1:0] d);
        valid[s]             = v;
        rd[s*5 +: 5]         = r;
        data[s*XLEN +: XLEN] = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [XLEN-1:0] d);
        exp_q.push_back('{a, d});
    endtask

    task automatic wait_idle(input string name);
        int cnt = 0;
        while (!idle && cnt < 20) begin
            tick();
            cnt++;
        end
        check(name, idle, 1'b1);
    endtask

    // Monitor: every RF write must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (we3 === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got a3=%0d wd3=%h, required no write", a3, wd3);
                end else begin
                    e = exp_q.pop_front();
                    if (a3 !== e.a || wd3 !== e.d) begin
                        n_err++;
                        $display("FAIL wb_write: got a3=%0d wd3=%h, required a3=%0d wd3=%h",
                                 a3, wd3, e.a, e.d);
                    end
                end
                rf_model[a3] = wd3;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int item;

        // Reset held with sources valid
        set_src(0, 1'b1, 5'd1, 64'h1);
        set_src(1, 1'b1, 5'd2, 64'h2);
        set_src(2, 1'b1, 5'd3, 64'h3);
        repeat (3) tick();
        check("rst_we3", we3, 1'b0);
        check("rst_pend", pend, 32'h0);
        check("rst_idle", idle, 1'b1);
        valid = '0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_ready", ready, 3'b111);

        // Single ALU write
        set_src(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
        expect_wr(5'd5, 64'hDEAD_BEEF);
        tick();
        set_src(0, 1'b0, 5'd0, 64'h0);
        check("single_we3_k", we3, 1'b0);
        check("single_pend_queued", pend, 32'h20);
        tick();
        check("single_we3", we3, 1'b1);
        check("single_a3", a3, 5'd5);
        check("single_wd3", wd3, 64'hDEAD_BEEF);
        check("single_pend_out", pend, 32'h20);
        @(negedge clk);
        #1;
        check("single_rf_x5", rf_model[5], 64'hDEAD_BEEF);
        tick();
        check("single_we3_drop", we3, 1'b0);
        check("single_pend_clear", pend, 32'h0);
        check("single_idle", idle, 1'b1);

        // MDU write leaves the pointer at 0
        set_src(2, 1'b1, 5'd7, 64'h7777);
        expect_wr(5'd7, 64'h7777);
        tick();
        set_src(2, 1'b0, 5'd0, 64'h0);
        wait_idle("mdu_idle");

        // Three-way burst, then a second overlapping burst
        set_src(0, 1'b1, 5'd1, 64'h101);
        set_src(1, 1'b1, 5'd2, 64'h102);
        set_src(2, 1'b1, 5'd3, 64'h103);
        expect_wr(5'd1, 64'h101);
        expect_wr(5'd2, 64'h102);
        expect_wr(5'd3, 64'h103);
        expect_wr(5'd10, 64'h10A);
        expect_wr(5'd12, 64'h10C);
        tick();
        set_src(0, 1'b1, 5'd10, 64'h10A);
        set_src(1, 1'b0, 5'd0, 64'h0);
        set_src(2, 1'b1, 5'd12, 64'h10C);
        tick();
        valid = '0;
        check("burst_we3", we3, 1'b1);
        check("burst_a3", a3, 5'd1);
        check("burst_pend", pend, 32'h0000_140E);
        wait_idle("burst_idle");

        // LSU backpressure while ALU/MDU entries compete for grants
        set_src(0, 1'b1, 5'd11, 64'hA0);
        set_src(2, 1'b1, 5'd13, 64'hC0);
        item = 0;
        set_src(1, 1'b1, 5'd20, 64'hB0);
        expect_wr(5'd11, 64'hA0);
        expect_wr(5'd20, 64'hB0);
        expect_wr(5'd13, 64'hC0);
        expect_wr(5'd21, 64'hB1);
        expect_wr(5'd22, 64'hB2);
        expect_wr(5'd23, 64'hB3);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("lsu_ready_%0d", i), ready[1], lsu_rdy_tbl[i]);
            tick();
            if (i == 0) begin
                set_src(0, 1'b0, 5'd0, 64'h0);
                set_src(2, 1'b0, 5'd0, 64'h0);
            end
            if (lsu_rdy_tbl[i]) begin
                item++;
                if (item == 4) set_src(1, 1'b0, 5'd0, 64'h0);
                else           set_src(1, 1'b1, 5'(20 + item), 64'hB0 + 64'(item));
            end
        end
        wait_idle("lsu_idle");

        // rd==0 is accepted and dropped
        set_src(0, 1'b1, 5'd0, {XLEN{1'b1}});
        check("x0_ready", ready[0], 1'b1);
        tick();
        set_src(0, 1'b0, 5'd0, 64'h0);
        check("x0_pend", pend, 32'h0);
        check("x0_idle", idle, 1'b1);
        tick();
        check("x0_we3", we3, 1'b0);
        check("x0_pend_later", pend, 32'h0);

        // Async reset with queued entries and a write in the output stage
        set_src(0, 1'b1, 5'd14, 64'hE);
        set_src(1, 1'b1, 5'd15, 64'hF);
        set_src(2, 1'b1, 5'd16, 64'h10);
        expect_wr(5'd16, 64'h10);
        tick();
        valid = '0;
        tick();
        check("prerst_we3", we3, 1'b1);
        check("prerst_a3", a3, 5'd16);
        check("prerst_pend", pend, 32'h0001_C000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_we3", we3, 1'b0);
        check("async_pend", pend, 32'h0);
        check("async_idle", idle, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post_rst_we3_%0d", i), we3, 1'b0);
        end
        check("post_rst_idle", idle, 1'b1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_core_rf_wb_arb
`default_nettype wire
